gnr_attractor_ctrl: RTL and testbench
=====================================

// Module: gnr_attractor_ctrl
// PURPOSE
//  Sequencer for an array of GNR node cells (dual-copy s0/s1 per node). Loads an initial network
//  state, then runs Floyd cycle detection: s1 (hare) steps every pulse, s0 (tortoise) every second pulse.
//  On s0==s1 it freezes s0, steps s1 alone to measure the attractor period, and reports the
//  transient step count, period and attractor state. Sits between the host/stimulus FIFO and the node array.
// PARAMETERS
//  N_NODES    8       number of nodes; width of state vectors
//  CNT_W      16      width of step and period counters
//  MAX_STEPS  65535   phase-1 pulse limit and phase-2 step limit before timeout
// PORTS
//  clk          in   1        clock
//  rst          in   1        asynchronous reset, active-low
//  start        in   1        run request; sampled only in IDLE
//  init_vec     in   N_NODES  initial network state; captured with start
//  s0_vec       in   N_NODES  concatenated node s0 outputs
//  s1_vec       in   N_NODES  concatenated node s1 outputs
//  reset_nos    out  1        load pulse to all nodes
//  init_state   out  N_NODES  per-node init bit; valid while reset_nos=1
//  start_s0     out  1        tortoise step enable
//  start_s1     out  1        hare step enable
//  busy         out  1        high from start acceptance until DONE
//  done         out  1        one-cycle pulse; results valid from this cycle
//  found        out  1        attractor detected (held until next start)
//  timeout      out  1        limit reached without detection (held)
//  steps        out  CNT_W    phase-1 pulses issued (held)
//  period       out  CNT_W    attractor length; 0 on timeout (held)
//  attr_state   out  N_NODES  s0_vec latched at detection (held)
// BEHAVIOUR
//  - rst=0 (any time, async): FSM->IDLE; all outputs and counters 0. No partial result survives.
//  - Strobes decoded from state register (Moore): node regs update on the edge leaving a STEP state;
//    next EVAL state sees updated vectors.
//  - IDLE: start=1 -> capture init_vec, clear found/timeout/steps/period/attr_state, busy=1 -> LOAD.
//  - LOAD (1 cycle): reset_nos=1, init_state=captured vec -> STEP1.
//  - STEP1 (1 cycle): start_s0=start_s1=1; steps++ -> EVAL1.
//    Node pass toggle gives s0 = ceil(steps/2) updates, s1 = steps updates.
//  - EVAL1: compare only when steps even: s0_vec==s1_vec -> latch attr_state=s0_vec, period=0 -> STEP2.
//    Else steps==MAX_STEPS -> timeout=1 -> DONE. Else -> STEP1. Detection beats timeout on same cycle.
//  - STEP2: start_s1=1 only; period++ -> EVAL2.
//  - EVAL2: s1_vec==s0_vec -> found=1 -> DONE; else period==MAX_STEPS -> timeout=1, period=0 -> DONE;
//    else -> STEP2.
//  - DONE (1 cycle): done=1, busy=0 -> IDLE. start in DONE ignored; accepted next cycle in IDLE.
//  - start while busy: ignored. Counters saturate-free: limit check precedes wrap (MAX_STEPS < 2^CNT_W).
//  - Latency: fixed point from init -> done 7 cycles after start
//    (LOAD, STEP1, EVAL1, STEP1, EVAL1, STEP2, EVAL2, DONE).
// STRUCTURE
//  - Shared package gnr_pkg: FSM state enum (IDLE, LOAD, STEP1, EVAL1, STEP2, EVAL2, DONE),
//    default CNT_W, MAX_STEPS.
//  - Single module; no sub-module needed. Equality compare is a plain N_NODES-bit ==.
// TESTING (bench: behavioural N_NODES net; next-state from table, driven by strobes per node semantics)
//  - Fixed point (next=x), init 8'h5A -> done, found=1, steps=2, period=1, attr_state=8'h5A, timeout=0.
//  - 3-cycle ring A->B->C->A, init A -> found=1, steps=6, period=3.
//  - Increment mod 4, init 0 -> found=1, steps=8, period=4, attr_state=0.
//  - Increment mod 8, MAX_STEPS=6 -> timeout=1, found=0, steps=6, period=0.
//  - rst low during STEP2 of ring test -> all outputs 0 at once; new start completes with same results.
//  - start asserted while busy and during DONE -> ignored; one done pulse per accepted start.

Source files
------------

// File: rtl/gnr_pkg.sv
// Shared types and defaults for the GNR attractor sequencer.
// Holds the FSM state encoding and the default counter sizing.
package gnr_pkg;

    localparam int GNR_N_NODES   = 8;
    localparam int GNR_CNT_W     = 16;
    localparam int GNR_MAX_STEPS = 65535;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_STEP1 = 3'd2,
        ST_EVAL1 = 3'd3,
        ST_STEP2 = 3'd4,
        ST_EVAL2 = 3'd5,
        ST_DONE  = 3'd6
    } gnr_state_e;

endpackage

// File: rtl/gnr_attractor_ctrl_if.sv
// Host-side run/result signals and node-array strobes/state vectors of the sequencer.
// master = sequencer, slave = host plus node array.
interface gnr_attractor_ctrl_if #(
    parameter int N_NODES = 8,
    parameter int CNT_W   = 16
);
    logic               start;
    logic [N_NODES-1:0] init_vec;
    logic [N_NODES-1:0] s0_vec;
    logic [N_NODES-1:0] s1_vec;
    logic               reset_nos;
    logic [N_NODES-1:0] init_state;
    logic               start_s0;
    logic               start_s1;
    logic               busy;
    logic               done;
    logic               found;
    logic               timeout;
    logic [CNT_W-1:0]   steps;
    logic [CNT_W-1:0]   period;
    logic [N_NODES-1:0] attr_state;

    modport master (
        input  start, init_vec, s0_vec, s1_vec,
        output reset_nos, init_state, start_s0, start_s1,
        output busy, done, found, timeout, steps, period, attr_state
    );

    modport slave (
        output start, init_vec, s0_vec, s1_vec,
        input  reset_nos, init_state, start_s0, start_s1,
        input  busy, done, found, timeout, steps, period, attr_state
    );
endinterface

// File: rtl/gnr_attractor_ctrl.sv
// Floyd cycle-detection sequencer for a dual-copy GNR node array; a fixed point reports done 7 cycles after start.
// No backpressure: start is a level request sampled only in IDLE, results hold until the next accepted start.
module gnr_attractor_ctrl
    import gnr_pkg::*;
#(
    parameter int N_NODES   = GNR_N_NODES,
    parameter int CNT_W     = GNR_CNT_W,
    parameter int MAX_STEPS = GNR_MAX_STEPS
) (
    input  logic                 clk,
    input  logic                 rst,
    gnr_attractor_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

    gnr_state_e         state_q, state_d;
    logic [N_NODES-1:0] vec_q, vec_d;
    logic [N_NODES-1:0] attr_q, attr_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               found_q, found_d;
    logic               timeout_q, timeout_d;
    logic               vec_eq;

    assign vec_eq = (bus.s0_vec == bus.s1_vec);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            attr_q    <= '0;
            steps_q   <= '0;
            period_q  <= '0;
            found_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            attr_q    <= attr_d;
            steps_q   <= steps_d;
            period_q  <= period_d;
            found_q   <= found_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        attr_d    = attr_q;
        steps_d   = steps_q;
        period_d  = period_q;
        found_d   = found_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    vec_d     = bus.init_vec;
                    attr_d    = '0;
                    steps_d   = '0;
                    period_d  = '0;
                    found_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_STEP1;
            ST_STEP1: begin
                steps_d = steps_q + CNT_W'(1);
                state_d = ST_EVAL1;
            end
            ST_EVAL1: begin
                // Tortoise only lands on a whole step after an even pulse count.
                if (!steps_q[0] && vec_eq) begin
                    attr_d   = bus.s0_vec;
                    period_d = '0;
                    state_d  = ST_STEP2;
                end else if (steps_q == MAX_CNT) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_STEP1;
                end
            end
            ST_STEP2: begin
                period_d = period_q + CNT_W'(1);
                state_d  = ST_EVAL2;
            end
            ST_EVAL2: begin
                if (vec_eq) begin
                    found_d = 1'b1;
                    state_d = ST_DONE;
                end else if (period_q == MAX_CNT) begin
                    timeout_d = 1'b1;
                    period_d  = '0;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_STEP2;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are pure decodes of the state register so the node array sees clean Moore pulses.
    assign bus.reset_nos  = (state_q == ST_LOAD);
    assign bus.init_state = (state_q == ST_LOAD) ? vec_q : '0;
    assign bus.start_s0   = (state_q == ST_STEP1);
    assign bus.start_s1   = (state_q == ST_STEP1) || (state_q == ST_STEP2);
    assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.found      = found_q;
    assign bus.timeout    = timeout_q;
    assign bus.steps      = steps_q;
    assign bus.period     = period_q;
    assign bus.attr_state = attr_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Two sequencers (default limit and limit 6) each driving a behavioural 8-node network from a lookup table.
module tb_gnr_attractor_ctrl;

    typedef struct packed {
        logic        found;
        logic        timeout;
        logic [15:0] steps;
        logic [15:0] period;
        logic [7:0]  attr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gnr_attractor_ctrl_if #(.N_NODES(8), .CNT_W(16)) ifa ();
    gnr_attractor_ctrl_if #(.N_NODES(8), .CNT_W(16)) ifb ();

    gnr_attractor_ctrl #(.N_NODES(8), .CNT_W(16), .MAX_STEPS(65535)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );
    gnr_attractor_ctrl #(.N_NODES(8), .CNT_W(16), .MAX_STEPS(6)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // Network next-state tables and node registers; s0 advances on every other s0 strobe.
    logic [7:0] fa [256];
    logic [7:0] fb [256];
    logic [7:0] a_s0 = 8'h0, a_s1 = 8'h0, b_s0 = 8'h0, b_s1 = 8'h0;
    logic       a_tog = 1'b0, b_tog = 1'b0;

    always @(posedge clk) begin
        if (ifa.reset_nos) begin
            a_s0 <= ifa.init_state; a_s1 <= ifa.init_state; a_tog <= 1'b0;
        end else begin
            if (ifa.start_s0) begin
                if (!a_tog) a_s0 <= fa[a_s0];
                a_tog <= ~a_tog;
            end
            if (ifa.start_s1) a_s1 <= fa[a_s1];
        end
    end
    always @(posedge clk) begin
        if (ifb.reset_nos) begin
            b_s0 <= ifb.init_state; b_s1 <= ifb.init_state; b_tog <= 1'b0;
        end else begin
            if (ifb.start_s0) begin
                if (!b_tog) b_s0 <= fb[b_s0];
                b_tog <= ~b_tog;
            end
            if (ifb.start_s1) b_s1 <= fb[b_s1];
        end
    end
    assign ifa.s0_vec = a_s0;
    assign ifa.s1_vec = a_s1;
    assign ifb.s0_vec = b_s0;
    assign ifb.s1_vec = b_s1;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] fnext(input int which, input logic [7:0] v);
        return (which == 0) ? fa[v] : fb[v];
    endfunction

    // Floyd search straight from the algorithm: hare moves every pulse, tortoise on odd pulses.
    function automatic exp_t ref_run(input int which, input logic [7:0] x);
        exp_t       e;
        int         lim = (which == 0) ? 65535 : 6;
        logic [7:0] t = x;
        logic [7:0] h = x;
        e = '0;
        for (int k = 1; k <= lim; k++) begin
            h = fnext(which, h);
            if (k % 2 == 1) t = fnext(which, t);
            if ((k % 2 == 0) && (t == h)) begin
                e.steps = 16'(k);
                e.attr  = t;
                for (int p = 1; p <= lim; p++) begin
                    h = fnext(which, h);
                    if (h == t) begin
                        e.found  = 1'b1;
                        e.period = 16'(p);
                        return e;
                    end
                end
                e.timeout = 1'b1;
                return e;
            end
            if (k == lim) begin
                e.steps   = 16'(k);
                e.timeout = 1'b1;
                return e;
            end
        end
        return e;
    endfunction

    // Scoreboard monitors: one pop per done pulse.
    always @(negedge clk) begin
        if (ifa.done) begin
            if (qa.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL a.spurious_done: got done=1 expected no pending run");
            end else begin
                ea = qa.pop_front();
                check("a.found",   32'(ifa.found),      32'(ea.found));
                check("a.timeout", 32'(ifa.timeout),    32'(ea.timeout));
                check("a.steps",   32'(ifa.steps),      32'(ea.steps));
                check("a.period",  32'(ifa.period),     32'(ea.period));
                check("a.attr",    32'(ifa.attr_state), 32'(ea.attr));
            end
        end
    end
    always @(negedge clk) begin
        if (ifb.done) begin
            if (qb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL b.spurious_done: got done=1 expected no pending run");
            end else begin
                eb = qb.pop_front();
                check("b.found",   32'(ifb.found),      32'(eb.found));
                check("b.timeout", 32'(ifb.timeout),    32'(eb.timeout));
                check("b.steps",   32'(ifb.steps),      32'(eb.steps));
                check("b.period",  32'(ifb.period),     32'(eb.period));
                check("b.attr",    32'(ifb.attr_state), 32'(eb.attr));
            end
        end
    end

    task automatic drive(input int which, input logic v, input logic [7:0] vec);
        if (which == 0) begin ifa.start = v; ifa.init_vec = vec; end
        else            begin ifb.start = v; ifb.init_vec = vec; end
    endtask

    function automatic logic done_of(input int which);
        return (which == 0) ? ifa.done : ifb.done;
    endfunction

    function automatic logic busy_of(input int which);
        return (which == 0) ? ifa.busy : ifb.busy;
    endfunction

    task automatic check_zero_a(input string tag);
        check({tag, ".busy"},       32'(ifa.busy),       32'd0);
        check({tag, ".done"},       32'(ifa.done),       32'd0);
        check({tag, ".found"},      32'(ifa.found),      32'd0);
        check({tag, ".timeout"},    32'(ifa.timeout),    32'd0);
        check({tag, ".steps"},      32'(ifa.steps),      32'd0);
        check({tag, ".period"},     32'(ifa.period),     32'd0);
        check({tag, ".attr"},       32'(ifa.attr_state), 32'd0);
        check({tag, ".reset_nos"},  32'(ifa.reset_nos),  32'd0);
        check({tag, ".init_state"}, 32'(ifa.init_state), 32'd0);
        check({tag, ".start_s0"},   32'(ifa.start_s0),   32'd0);
        check({tag, ".start_s1"},   32'(ifa.start_s1),   32'd0);
    endtask

    // One accepted run; start stays high (with a different vector) through busy and DONE.
    task automatic run(input int which, input logic [7:0] x, input bit chk_lat);
        int lat = 0;
        bit ok  = 1'b0;
        if (which == 0) qa.push_back(ref_run(which, x));
        else            qb.push_back(ref_run(which, x));
        @(negedge clk);
        drive(which, 1'b1, x);
        @(posedge clk);
        #1 drive(which, 1'b1, ~x);
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (done_of(which)) begin ok = 1'b1; break; end
            @(posedge clk);
            lat++;
        end
        if (!ok) begin
            $display("FAIL run_wait: got no done within 5000 cycles expected done (unit %0d)", which);
            n_fail++;
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks + 1, n_fail);
            $fatal(1, "no done");
        end
        if (chk_lat) check("latency", 32'(lat), 32'd7);
        @(posedge clk);
        #1 drive(which, 1'b0, x);
        @(negedge clk);
        check("busy_after_done", 32'(busy_of(which)), 32'd0);
    endtask

    task automatic ring_table();
        for (int i = 0; i < 256; i++) fa[i] = 8'(i);
        fa[8'h11] = 8'h22; fa[8'h22] = 8'h33; fa[8'h33] = 8'h11;
    endtask

    initial begin
        bit seen;
        drive(0, 1'b0, 8'h0);
        drive(1, 1'b0, 8'h0);
        for (int i = 0; i < 256; i++) begin fa[i] = 8'(i); fb[i] = 8'(i); end
        #2;
        check_zero_a("reset");
        check("reset.b_busy", 32'(ifb.busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Fixed point: also checks start-to-done latency.
        run(0, 8'h5A, 1'b1);

        ring_table();
        run(0, 8'h11, 1'b0);

        for (int i = 0; i < 256; i++) fa[i] = 8'((i + 1) & 3);
        run(0, 8'h00, 1'b0);

        for (int i = 0; i < 256; i++) fb[i] = 8'((i + 1) & 7);
        run(1, 8'h00, 1'b0);

        // Reset in the middle of period measurement, then rerun.
        ring_table();
        qa.push_back(ref_run(0, 8'h11));
        @(negedge clk);
        drive(0, 1'b1, 8'h11);
        @(posedge clk);
        #1 drive(0, 1'b0, 8'h11);
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (ifa.start_s1 && !ifa.start_s0) begin seen = 1'b1; break; end
        end
        check("reach_step2", 32'(seen), 32'd1);
        rst = 1'b0;
        #1;
        check_zero_a("midreset");
        qa.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run(0, 8'h11, 1'b0);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 256; i++) fa[i] = 8'($urandom_range(0, 255));
            run(0, 8'($urandom_range(0, 255)), 1'b0);
        end
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 256; i++) fb[i] = 8'($urandom_range(0, 7));
            run(1, 8'($urandom_range(0, 255)), 1'b0);
        end

        repeat (5) @(negedge clk);
        check("a.queue_empty", 32'(qa.size()), 32'd0);
        check("b.queue_empty", 32'(qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
